dm_pipe: RTL

DM_PIPE -- requirements
Module: dm_pipe

---
 rtl/dm_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dm_pipe.sv
// Data memory with byte/half/word loads and stores, a one-cycle response, and
// a post-reset clear of every word. Define DM_WRITE_TRACE_EN to print each committed store.
module dm_pipe #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              req_err;
  logic              accept;
  logic              store_commit;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;
  logic [31:0]       load_data;
  logic [3:0]        lane_en;
  logic [31:0]       lane_data;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  always_ff @(posedge clk) begin
    if (!reset) state <= CLEAR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (&clr_cnt) state_next = IDLE;
      IDLE:    state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)              clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  assign req_ready = (state == IDLE);
  assign init_done = (state == IDLE);

  assign word_idx     = req_addr[ADDR_W+1:2];
  assign lane         = req_addr[1:0];
  assign accept       = req_valid && req_ready;
  assign store_commit = accept && req_we && !req_err && reset;
  assign old_word     = mem[word_idx];

  // Out-of-range upper bits are checked so high addresses never alias low words.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                          req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])           req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (|req_addr[31:ADDR_W+2])                     req_err = 1'b1;
  end

  always_comb begin
    lane_en   = 4'b1111;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        lane_en   = 4'b0001 << lane;
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged_word[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  always_comb begin
    sel_byte  = old_word[{lane, 3'b000} +: 8];
    sel_half  = req_addr[1] ? old_word[31:16] : old_word[15:0];
    load_data = old_word;
    case (req_size)
      2'b00:   load_data = req_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_data = req_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (store_commit) begin
      mem[word_idx] <= merged_word;
`ifdef DM_WRITE_TRACE_EN
      $display("%0t@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged_word);
`endif
    end
  end

`ifndef DM_WRITE_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && req_err;
      rsp_rdata <= (accept && !req_we && !req_err) ? load_data : '0;
    end
  end

endmodule
